// File: rtl/vec_to_rgb_if.sv
// Handshake bundle between the FP27 vector source, the RGB converter and the pixel sink.
interface vec_to_rgb_if #(
  parameter int unsigned CHAN_BITS = 8
);
  localparam int unsigned FP_W  = 27;
  localparam int unsigned RGB_W = 3 * CHAN_BITS;

  logic              i_valid;
  logic              o_ready;
  logic [FP_W-1:0]   i_x;
  logic [FP_W-1:0]   i_y;
  logic [FP_W-1:0]   i_z;
  logic              o_valid;
  logic              i_ready;
  logic [RGB_W-1:0]  o_rgb;
  logic              o_sat;

  modport master (
    output i_valid, i_x, i_y, i_z, i_ready,
    input  o_ready, o_valid, o_rgb, o_sat
  );

  modport slave (
    input  i_valid, i_x, i_y, i_z, i_ready,
    output o_ready, o_valid, o_rgb, o_sat
  );
endinterface

// File: rtl/vec_to_rgb.sv
// FP27 (x,y,z) to packed fixed-point RGB; one float-to-fixed datapath shared
// across the three channels by a five-state sequencer.
module vec_to_rgb #(
  parameter int unsigned CHAN_BITS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  vec_to_rgb_if.slave bus
);
  localparam int unsigned FP_W    = 27;
  localparam int unsigned MAN_W   = 18;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned RGB_W   = 3 * CHAN_BITS;

  localparam logic [EXP_W-1:0]     EXP_ONE    = EXP_W'(127);
  localparam logic [EXP_W-1:0]     EXP_LOW    = EXP_W'(127 - CHAN_BITS);
  localparam logic [EXP_W-1:0]     SHIFT_BASE = EXP_W'(MAN_W);
  localparam logic [CHAN_BITS-1:0] CHAN_MAX   = '1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CONV_X = 3'd1;
  localparam logic [2:0] CONV_Y = 3'd2;
  localparam logic [2:0] CONV_Z = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic                 accept;

  logic [FP_W-1:0]      cap_x;
  logic [FP_W-1:0]      cap_y;
  logic [FP_W-1:0]      cap_z;
  logic [FP_W-1:0]      sel;
  logic                 sat_acc;

  logic [EXP_W-1:0]     exp_f;
  logic [MAN_W:0]       man_f;
  logic [SHIFT_W-1:0]   shift;
  logic [CHAN_BITS-1:0] conv;
  logic                 conv_clamp;

  logic                 ready_q;
  logic                 valid_q;
  logic [RGB_W-1:0]     rgb_q;
  logic                 sat_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Sequencing: capture in IDLE, one channel per cycle, hold in DONE until taken
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          accept     = 1'b1;
          state_next = CONV_X;
        end
      end
      CONV_X:  state_next = CONV_Y;
      CONV_Y:  state_next = CONV_Z;
      CONV_Z:  state_next = DONE;
      DONE:    if (bus.i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Channel select for the shared converter
  always_comb begin
    sel = cap_x;
    case (state)
      CONV_Y:  sel = cap_y;
      CONV_Z:  sel = cap_z;
      default: sel = cap_x;
    endcase
  end

  // floor(v * 2^CHAN_BITS) clamped to the channel range; underflow is not a clamp
  always_comb begin
    exp_f      = sel[FP_W-2 -: EXP_W];
    man_f      = {1'b1, sel[MAN_W-1:0]};
    shift      = SHIFT_W'(SHIFT_BASE - (exp_f - EXP_LOW));
    conv       = '0;
    conv_clamp = 1'b0;
    if (exp_f == '0) begin
      conv = '0;
    end else if (sel[FP_W-1]) begin
      conv_clamp = 1'b1;
    end else if (exp_f >= EXP_ONE) begin
      conv       = CHAN_MAX;
      conv_clamp = 1'b1;
    end else if (exp_f < EXP_LOW) begin
      conv = '0;
    end else begin
      conv = CHAN_BITS'(man_f >> shift);
    end
  end

  // Capture registers, per-channel result fields and saturation flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cap_x   <= '0;
      cap_y   <= '0;
      cap_z   <= '0;
      sat_acc <= 1'b0;
      rgb_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (accept) begin
        cap_x   <= bus.i_x;
        cap_y   <= bus.i_y;
        cap_z   <= bus.i_z;
        sat_acc <= 1'b0;
      end
      case (state)
        CONV_X: begin
          rgb_q[2*CHAN_BITS +: CHAN_BITS] <= conv;
          sat_acc                         <= sat_acc | conv_clamp;
        end
        CONV_Y: begin
          rgb_q[CHAN_BITS +: CHAN_BITS] <= conv;
          sat_acc                       <= sat_acc | conv_clamp;
        end
        CONV_Z: begin
          rgb_q[0 +: CHAN_BITS] <= conv;
          sat_q                 <= sat_acc | conv_clamp;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags registered from the next state so they track it exactly
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      ready_q <= (state_next == IDLE);
      valid_q <= (state_next == DONE);
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_rgb   = rgb_q;
  assign bus.o_sat   = sat_q;

endmodule

// File: tb/tb_vec_to_rgb.sv
// Bench for vec_to_rgb: directed vectors plus a random stream, checked every
// cycle against a real-arithmetic model of the conversion and handshake timing.
module tb_vec_to_rgb;
  localparam int unsigned CB    = 8;
  localparam int unsigned MAXV  = (1 << CB) - 1;
  localparam int unsigned PIX_W = 3 * CB + 1;

  logic clk = 1'b0;
  logic rst;
  logic fix_rdy;
  logic rand_rdy;
  bit   rand_mode;

  vec_to_rgb_if #(.CHAN_BITS(CB)) bus ();
  assign bus.i_ready = rand_mode ? rand_rdy : fix_rdy;

  vec_to_rgb #(.CHAN_BITS(CB)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Channel value from the real number the FP27 word encodes
  function automatic logic [CB:0] model_chan(input logic [26:0] v);
    int  e;
    real r;
    e = int'(v[25:18]);
    if (e == 0)   return {1'b0, CB'(0)};
    if (v[26])    return {1'b1, CB'(0)};
    if (e == 255) return {1'b1, CB'(MAXV)};
    r = 1.0 + real'(v[17:0]) / 262144.0;
    for (int i = e; i < 127; i++) r = r / 2.0;
    for (int i = 127; i < e; i++) r = r * 2.0;
    for (int i = 0; i < int'(CB); i++) r = r * 2.0;
    if (r >= real'(MAXV + 1)) return {1'b1, CB'(MAXV)};
    return {1'b0, CB'($rtoi(r))};
  endfunction

  function automatic logic [PIX_W-1:0] model_pix(input logic [26:0] x, input logic [26:0] y, input logic [26:0] z);
    logic [CB:0] a, b, c;
    a = model_chan(x);
    b = model_chan(y);
    c = model_chan(z);
    return {a[CB] | b[CB] | c[CB], a[CB-1:0], b[CB-1:0], c[CB-1:0]};
  endfunction

  // Reference state for the per-cycle compare process
  logic [PIX_W-1:0] q[$];
  int  cyc = 0;
  int  acc_cyc = 0;
  int  last_acc = 0;
  bit  busy = 1'b0;
  bit  have_last = 1'b0;
  bit  exp_valid;
  int  accepts = 0;
  int  pixels = 0;
  int  dropped = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (busy) dropped++;
        busy      = 1'b0;
        have_last = 1'b0;
        q.delete();
      end else begin
        exp_valid = busy && (cyc - acc_cyc >= 4);
        chk(bus.o_ready == !busy, "o_ready", 32'(bus.o_ready), 32'(!busy));
        chk(bus.o_valid == exp_valid, "o_valid", 32'(bus.o_valid), 32'(exp_valid));
        if (exp_valid && bus.o_valid && q.size() > 0)
          chk({bus.o_sat, bus.o_rgb} == q[0], "pixel", 32'({bus.o_sat, bus.o_rgb}), 32'(q[0]));
        if (bus.i_valid && !busy) begin
          if (have_last) chk(cyc - last_acc >= 5, "accept_spacing", 32'(cyc - last_acc), 32'd5);
          q.push_back(model_pix(bus.i_x, bus.i_y, bus.i_z));
          last_acc  = cyc;
          acc_cyc   = cyc;
          have_last = 1'b1;
          busy      = 1'b1;
          accepts++;
        end else if (exp_valid && bus.i_ready) begin
          void'(q.pop_front());
          busy = 1'b0;
          pixels++;
        end
      end
    end
  end

  // Random downstream backpressure
  initial begin
    rand_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rand_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Hold i_valid until o_ready is seen; returns negedges waited (0 on timeout)
  task automatic wait_accept(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        n = i;
        break;
      end
    end
    chk(n != 0, "accept_timeout", 32'(n), 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic send(input logic [26:0] x, input logic [26:0] y, input logic [26:0] z, input int limit);
    int n;
    bus.i_x     = x;
    bus.i_y     = y;
    bus.i_z     = z;
    bus.i_valid = 1'b1;
    wait_accept(limit, n);
  endtask

  // Called just after the accept edge; checks edges-to-valid and the literal pixel
  task automatic wait_pixel(input logic [PIX_W-1:0] exp, input string name, input int exp_lat);
    int n;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        n = i;
        break;
      end
    end
    chk(n != 0, "valid_timeout", 32'(n), 32'd1);
    if (exp_lat >= 0) chk(n - 1 == exp_lat, "latency", 32'(n - 1), 32'(exp_lat));
    chk({bus.o_sat, bus.o_rgb} == exp, name, 32'({bus.o_sat, bus.o_rgb}), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] rand_fp();
    logic       s;
    logic [7:0] e;
    int         k;
    s = ($urandom_range(0, 5) == 0);
    k = int'($urandom_range(0, 9));
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'd255;
    else if (k == 2) e = 8'(127 + $urandom_range(0, 3));
    else             e = 8'(112 + $urandom_range(0, 15));
    return {s, e, 18'($urandom_range(0, 262143))};
  endfunction

  initial begin
    int snap;
    int n;
    logic [26:0] rx, ry, rz;
    rst         = 1'b1;
    fix_rdy     = 1'b1;
    rand_mode   = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_x     = '0;
    bus.i_y     = '0;
    bus.i_z     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk(bus.o_ready == 1'b1, "reset_ready", 32'(bus.o_ready), 32'd1);
    chk(bus.o_valid == 1'b0, "reset_valid", 32'(bus.o_valid), 32'd0);
    chk(bus.o_rgb == '0,     "reset_rgb",   32'(bus.o_rgb), 32'd0);
    chk(bus.o_sat == 1'b0,   "reset_sat",   32'(bus.o_sat), 32'd0);

    chk(model_chan(27'h1FC0000) == 9'h1FF, "model_one",   32'(model_chan(27'h1FC0000)), 32'h1FF);
    chk(model_chan(27'h1FA0000) == 9'h0C0, "model_075",   32'(model_chan(27'h1FA0000)), 32'h0C0);
    chk(model_chan(27'h1DC0000) == 9'h001, "model_1_256", 32'(model_chan(27'h1DC0000)), 32'h001);
    chk(model_chan(27'h1D80000) == 9'h000, "model_1_512", 32'(model_chan(27'h1D80000)), 32'h000);
    chk(model_chan(27'h5F80000) == 9'h100, "model_neg",   32'(model_chan(27'h5F80000)), 32'h100);
    chk(model_chan(27'h2000000) == 9'h1FF, "model_two",   32'(model_chan(27'h2000000)), 32'h1FF);
    chk(model_chan(27'h3FC0001) == 9'h1FF, "model_nan",   32'(model_chan(27'h3FC0001)), 32'h1FF);
    chk(model_chan(27'h4000000) == 9'h000, "model_negz",  32'(model_chan(27'h4000000)), 32'h000);

    @(posedge clk);
    #1;
    send(27'h1FC0000, 27'h1F80000, 27'h1F40000, 50);
    wait_pixel({1'b1, 24'hFF8040}, "basic_pixel", 3);
    @(negedge clk);
    chk(bus.o_ready == 1'b1, "ready_after_e4", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;

    send(27'h1FA0000, 27'h1DC0000, 27'h1D80000, 50);
    wait_pixel({1'b0, 24'hC00100}, "trunc_pixel", 3);
    send(27'h5F80000, 27'h2000000, 27'h3FC0001, 50);
    wait_pixel({1'b1, 24'h00FFFF}, "clamp_pixel", 3);
    send(27'h4000000, 27'h4000000, 27'h4000000, 50);
    wait_pixel({1'b0, 24'h000000}, "negzero_pixel", 3);

    // Backpressure in DONE with a new vector waiting at the input
    fix_rdy = 1'b0;
    send(27'h1FA0000, 27'h1F80000, 27'h1DC0000, 50);
    wait_pixel({1'b0, 24'hC08001}, "bp_first_pixel", 3);
    bus.i_x     = 27'h1F40000;
    bus.i_y     = 27'h1FC0000;
    bus.i_z     = 27'h4000000;
    bus.i_valid = 1'b1;
    snap = 32'({bus.o_sat, bus.o_rgb});
    repeat (10) begin
      @(negedge clk);
      chk(bus.o_valid == 1'b1, "bp_valid_held", 32'(bus.o_valid), 32'd1);
      chk(32'({bus.o_sat, bus.o_rgb}) == snap, "bp_pixel_held", 32'({bus.o_sat, bus.o_rgb}), snap);
      chk(bus.o_ready == 1'b0, "bp_ready_low", 32'(bus.o_ready), 32'd0);
    end
    @(posedge clk);
    #1 fix_rdy = 1'b1;
    wait_accept(10, n);
    chk(n == 2, "bp_held_accept", 32'(n), 32'd2);
    wait_pixel({1'b1, 24'h40FF00}, "bp_second_pixel", 3);

    // Reset while converting the Y channel
    send(27'h1FC0000, 27'h1FC0000, 27'h1FC0000, 50);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk(bus.o_valid == 1'b0, "rst_mid_valid", 32'(bus.o_valid), 32'd0);
      chk(bus.o_rgb == '0,     "rst_mid_rgb",   32'(bus.o_rgb), 32'd0);
      chk(bus.o_ready == 1'b1, "rst_mid_ready", 32'(bus.o_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    send(27'h1F80000, 27'h1F40000, 27'h1FA0000, 50);
    wait_pixel({1'b0, 24'h8040C0}, "post_rst_pixel", 3);

    // Random stream with input gaps and output backpressure
    rand_mode = 1'b1;
    for (int v = 0; v < 100; v++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      rx = rand_fp();
      ry = rand_fp();
      rz = rand_fp();
      send(rx, ry, rz, 200);
    end
    rand_mode = 1'b0;
    fix_rdy   = 1'b1;
    for (int i = 0; i < 100 && busy; i++) @(posedge clk);
    @(negedge clk);
    chk(!busy, "drain", 32'(busy), 32'd0);
    chk(q.size() == 0, "queue_empty", 32'(q.size()), 32'd0);
    chk(accepts == 108, "accept_count", 32'(accepts), 32'd108);
    chk(pixels == 107 && dropped == 1, "pixel_count", 32'(pixels), 32'd107);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
